// File: rtl/debug_reg_dumper_pkg.sv
// Shared constants, state encodings and small helpers for the register dumper.
package debug_reg_dumper_pkg;

  // Default geometry of the dumped register file and the UART byte lane.
  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_BYTE_DEF = 8;
  localparam int N_REGS_DEF  = 32;

  // Number of UART bytes carried by one register word at the default sizes.
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  // Dump sequencer state encodings.
  localparam logic [2:0] DUMP_IDLE     = 3'd0;
  localparam logic [2:0] DUMP_SET_ADDR = 3'd1;
  localparam logic [2:0] DUMP_CAPTURE  = 3'd2;
  localparam logic [2:0] DUMP_SEND     = 3'd3;
  localparam logic [2:0] DUMP_WAIT_TX  = 3'd4;
  localparam logic [2:0] DUMP_DONE     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = DUMP_IDLE,
    ST_SET_ADDR = DUMP_SET_ADDR,
    ST_CAPTURE  = DUMP_CAPTURE,
    ST_SEND     = DUMP_SEND,
    ST_WAIT_TX  = DUMP_WAIT_TX,
    ST_DONE     = DUMP_DONE
  } dump_state_t;

  // Bytes per word for an arbitrary word/byte geometry.
  function automatic int bytes_per_word(input int nb_data, input int nb_byte);
    return nb_data / nb_byte;
  endfunction

  // Counter width able to index n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_reg_dumper_if.sv
// Bundle of the dumper's control, register-file debug port and UART TX handshake.
interface debug_reg_dumper_if
  import debug_reg_dumper_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) ();

  logic               start;           // one-cycle dump request
  logic [NB_DATA-1:0] reg_data;        // word returned by the DECODE debug port
  logic               tx_done;         // UART TX finished the current byte
  logic               read_debug_reg;  // DECODE debug port ownership
  logic [NB_REG-1:0]  addr_debug;      // DECODE debug read address
  logic [NB_BYTE-1:0] tx_data;         // byte handed to UART TX
  logic               tx_start;        // one-cycle UART TX start pulse
  logic               busy;            // dump in progress
  logic               done;            // one-cycle end-of-dump pulse

  // Dumper side: consumes requests/data, drives the debug port and TX.
  modport master (
    input  start, reg_data, tx_done,
    output read_debug_reg, addr_debug, tx_data, tx_start, busy, done
  );

  // Environment side: debug unit control, DECODE stage and UART TX.
  modport slave (
    output start, reg_data, tx_done,
    input  read_debug_reg, addr_debug, tx_data, tx_start, busy, done
  );

endinterface

// File: rtl/debug_reg_dumper_reg_word_serializer.sv
// Holds one captured register word and presents it MSB byte first.
module reg_word_serializer
  import debug_reg_dumper_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               load,
  input  logic               advance,
  input  logic [NB_DATA-1:0] word,
  output logic [NB_BYTE-1:0] msb_byte,
  output logic               last_byte
);

  localparam int BPW   = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int IDX_W = idx_width(BPW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [NB_DATA-1:0] shift_reg;
  logic [IDX_W-1:0]   byte_idx_reg;

  // Load a fresh word, or slide the next byte into the MSB slot on advance.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      shift_reg    <= '0;
      byte_idx_reg <= '0;
    end else if (load) begin
      shift_reg    <= word;
      byte_idx_reg <= '0;
    end else if (advance) begin
      shift_reg    <= shift_reg << NB_BYTE;
      byte_idx_reg <= byte_idx_reg + IDX_W'(1);
    end
  end

  assign msb_byte  = shift_reg[NB_DATA-1 -: NB_BYTE];
  assign last_byte = (byte_idx_reg == LAST_IDX);

endmodule

// File: rtl/debug_reg_dumper.sv
// Sweeps the DECODE register file through its debug port and streams every
// word to the UART transmitter, most significant byte first.
module debug_reg_dumper
  import debug_reg_dumper_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_BYTE = NB_BYTE_DEF,
  parameter int N_REGS  = N_REGS_DEF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  debug_reg_dumper_if.master  bus
);

  localparam logic [NB_REG-1:0] LAST_ADDR = NB_REG'(N_REGS - 1);

  dump_state_t        state_reg;
  logic [NB_REG-1:0]  addr_reg;
  logic               read_reg;
  logic [NB_BYTE-1:0] tx_data_reg;
  logic               tx_start_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [NB_BYTE-1:0] ser_byte;
  logic               ser_last;
  logic               ser_load;
  logic               ser_advance;
  logic               tx_done_accept;

  // A done pulse only counts in WAIT_TX and not in the cycle the start pulse
  // is still on the wire, so a stale or early done can never skip a byte.
  assign tx_done_accept = (state_reg == ST_WAIT_TX) && bus.tx_done && !tx_start_reg;
  assign ser_load       = (state_reg == ST_CAPTURE);
  assign ser_advance    = tx_done_accept && !ser_last;

  reg_word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .load      (ser_load),
    .advance   (ser_advance),
    .word      (bus.reg_data),
    .msb_byte  (ser_byte),
    .last_byte (ser_last)
  );

  // Dump sequencer with all outputs registered; pulses default low each cycle.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      read_reg     <= 1'b0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            addr_reg  <= '0;
            read_reg  <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= ST_SET_ADDR;
          end
        end
        ST_SET_ADDR: begin
          // Register file presents the word for the new address next cycle.
          state_reg <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          tx_data_reg  <= ser_byte;
          tx_start_reg <= 1'b1;
          state_reg    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done_accept) begin
            if (!ser_last) begin
              state_reg <= ST_SEND;
            end else if (addr_reg == LAST_ADDR) begin
              state_reg <= ST_DONE;
            end else begin
              addr_reg  <= addr_reg + NB_REG'(1);
              state_reg <= ST_SET_ADDR;
            end
          end
        end
        ST_DONE: begin
          // Hand the debug port back in the same cycle the done pulse rises.
          done_reg  <= 1'b1;
          read_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.read_debug_reg = read_reg;
  assign bus.addr_debug     = addr_reg;
  assign bus.tx_data        = tx_data_reg;
  assign bus.tx_start       = tx_start_reg;
  assign bus.busy           = busy_reg;
  assign bus.done           = done_reg;

endmodule

// File: tb/tb_debug_reg_dumper.sv
// Self-checking bench for debug_reg_dumper: register-file and UART TX models
// around the DUT, expected bytes queued at dump start and popped per tx_start.
module tb_debug_reg_dumper;
  import debug_reg_dumper_pkg::*;

  localparam int N_BYTES = N_REGS_DEF * BYTES_PER_WORD;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   reg_mode;
  logic [7:0] exp_q[$];

  logic       prev_rd_m;
  logic [4:0] prev_addr_m;

  debug_reg_dumper_if bus ();

  debug_reg_dumper dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input int mode, input int a);
    logic [7:0] a8;
    a8 = 8'(a);
    if (mode == 0) return 32'h1122_3344;
    return {a8, 24'hA5A5A5};
  endfunction

  // Register file model: the word is valid only in the cycle right after the
  // address changes (or the port is claimed); otherwise it returns garbage.
  always @(posedge clock) begin
    prev_rd_m   <= bus.read_debug_reg;
    prev_addr_m <= bus.addr_debug;
    if (bus.read_debug_reg && (!prev_rd_m || bus.addr_debug != prev_addr_m))
      bus.reg_data <= word_of(reg_mode, int'(bus.addr_debug));
    else
      bus.reg_data <= ~word_of(reg_mode, int'(bus.addr_debug));
  end

  task automatic push_dump(input int mode);
    logic [31:0] w;
    for (int a = 0; a < N_REGS_DEF; a++) begin
      w = word_of(mode, a);
      for (int b = 0; b < BYTES_PER_WORD; b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
  endtask

  // Issue i_start, then act as the UART TX and check each byte on tx_start.
  task automatic run_dump(input int resp, input int max_cycles, input int start_at,
                          input bit spurious, input int abort_at,
                          output int nbytes, output int ndone);
    int cnt; int tail; int cyc; bit injected; logic [4:0] prev_addr; logic [7:0] exp;
    nbytes = 0; ndone = 0; cnt = 0; tail = 0; cyc = 0; injected = 0;
    @(negedge clock);
    bus.start = 1'b1;
    prev_addr = bus.addr_debug;
    while (1) begin
      @(negedge clock);
      cyc++;
      if (bus.tx_start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte extra byte %0d got %02h expected none", nbytes, bus.tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (bus.tx_data !== exp) begin
            errors++;
            $display("FAIL tx_byte %0d got %02h expected %02h", nbytes, bus.tx_data, exp);
          end
        end
        checks++;
        if (bus.addr_debug !== 5'(nbytes / BYTES_PER_WORD)) begin
          errors++;
          $display("FAIL addr_order byte %0d got %0d expected %0d",
                   nbytes, bus.addr_debug, nbytes / BYTES_PER_WORD);
        end
        nbytes++;
        cnt = resp;
      end
      if (bus.done) begin
        ndone++;
        checks++;
        if (bus.read_debug_reg !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL done_release read=%b busy=%b expected 0 0", bus.read_debug_reg, bus.busy);
        end
      end
      bus.start   = 1'b0;
      bus.tx_done = 1'b0;
      if (abort_at >= 0 && nbytes >= abort_at) break;
      if (ndone > 0) begin
        tail++;
        if (tail > 4) break;
      end
      if (cyc > max_cycles) begin
        errors++;
        $display("FAIL run_dump_timeout got %0d bytes expected %0d", nbytes, N_BYTES);
        break;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.tx_done = 1'b1;
      end
      if (spurious && cnt == 0 && bus.addr_debug != prev_addr) bus.tx_done = 1'b1;
      if (start_at >= 0 && nbytes == start_at && !injected) begin
        bus.start = 1'b1;
        injected  = 1'b1;
      end
      prev_addr = bus.addr_debug;
    end
  endtask

  task automatic check_full(input string name, input int nbytes, input int ndone);
    checks++;
    if (nbytes != N_BYTES || ndone != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s got bytes=%0d dones=%0d left=%0d expected %0d 1 0",
               name, nbytes, ndone, exp_q.size(), N_BYTES);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.tx_done = 1'b0;
    reg_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.read_debug_reg, bus.addr_debug, bus.tx_data, bus.tx_start, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b addr=%0d data=%02h st=%b busy=%b done=%b expected all 0",
               bus.read_debug_reg, bus.addr_debug, bus.tx_data, bus.tx_start, bus.busy, bus.done);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.read_debug_reg !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b rd=%b expected 0 0", bus.busy, bus.read_debug_reg);
    end
    $display("test_reset done");
  endtask

  task automatic test_const_word();
    int nb; int nd;
    reg_mode = 0;
    push_dump(0);
    run_dump(5, 5000, -1, 0, -1, nb, nd);
    check_full("const_dump", nb, nd);
    $display("test_const_word bytes=%0d dones=%0d", nb, nd);
  endtask

  task automatic test_addr_word();
    int nb; int nd;
    reg_mode = 1;
    push_dump(1);
    run_dump(5, 5000, -1, 0, -1, nb, nd);
    check_full("addr_dump", nb, nd);
    $display("test_addr_word bytes=%0d dones=%0d", nb, nd);
  endtask

  task automatic test_ignored_inputs();
    int nb; int nd;
    reg_mode = 1;
    push_dump(1);
    run_dump(5, 5000, 10, 1, -1, nb, nd);
    check_full("ignored_inputs_dump", nb, nd);
    $display("test_ignored_inputs bytes=%0d dones=%0d", nb, nd);
  endtask

  task automatic test_stall();
    int bad; int waited;
    reg_mode = 0;
    bad = 0; waited = 0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    while (!bus.tx_start && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h11) begin
      errors++;
      $display("FAIL stall_first_byte got st=%b data=%02h expected 1 11", bus.tx_start, bus.tx_data);
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h11 || bus.busy !== 1'b1 || bus.done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad cycles expected 0", bad);
    end
    do_reset();
    $display("test_stall bad_cycles=%0d", bad);
  endtask

  task automatic test_async_reset();
    int nb; int nd; int spurious_done;
    reg_mode = 1;
    push_dump(1);
    // Byte index 30 is register 7, byte 2.
    run_dump(5, 5000, -1, 0, 31, nb, nd);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.read_debug_reg, bus.addr_debug, bus.tx_data, bus.tx_start, bus.busy, bus.done} !== '0) begin
      errors++;
      $display("FAIL async_reset got rd=%b addr=%0d data=%02h st=%b busy=%b done=%b expected all 0",
               bus.read_debug_reg, bus.addr_debug, bus.tx_data, bus.tx_start, bus.busy, bus.done);
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    spurious_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious_done++;
    end
    checks++;
    if (spurious_done != 0 || nd != 0) begin
      errors++;
      $display("FAIL reset_no_done got %0d bad cycles, %0d dones expected 0 0", spurious_done, nd);
    end
    push_dump(1);
    run_dump(5, 5000, -1, 0, -1, nb, nd);
    check_full("restart_dump", nb, nd);
    $display("test_async_reset restart bytes=%0d dones=%0d", nb, nd);
  endtask

  task automatic test_timing();
    logic [31:0] w;
    reg_mode = 1;
    w = word_of(1, 0);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.read_debug_reg !== 1'b1 || bus.addr_debug !== 5'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL timing_k got rd=%b addr=%0d busy=%b expected 1 0 1",
               bus.read_debug_reg, bus.addr_debug, bus.busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL timing_k1 got tx_start=%b expected 0", bus.tx_start);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.tx_start !== 1'b0) begin
      errors++;
      $display("FAIL timing_k2 got tx_start=%b expected 0", bus.tx_start);
    end
    @(posedge clock);
    #1;
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== w[31:24]) begin
      errors++;
      $display("FAIL timing_k3 got tx_start=%b data=%02h expected 1 %02h",
               bus.tx_start, bus.tx_data, w[31:24]);
    end
    do_reset();
    $display("test_timing done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_const_word();
    test_addr_word();
    test_ignored_inputs();
    test_stall();
    test_async_reset();
    test_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
